// File: rtl/contador_limite_m_pkg.sv
// Shared constants for the limit counter and the control units that drive it.
package contador_limite_m_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODO_WRAP = 1'b0;
    localparam logic MODO_SAT  = 1'b1;

    typedef enum logic [1:0] {
        ACAO_HOLD,
        ACAO_CONTA,
        ACAO_CARGA,
        ACAO_LIMPA
    } acao_t;

    function automatic acao_t decide_acao(
        input logic clr,
        input logic ld,
        input logic conta
    );
        if (clr)
            return ACAO_LIMPA;
        else if (ld)
            return ACAO_CARGA;
        else if (conta)
            return ACAO_CONTA;
        else
            return ACAO_HOLD;
    endfunction

endpackage

// File: rtl/comparador_limite.sv
// Terminal-condition comparator shared by rco and the next-state logic.
module comparador_limite
    import contador_limite_m_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] q,
    input  logic [N-1:0] lim,
    input  logic         dir,
    output logic         t
);

    always_comb begin
        t = 1'b0;
        if (dir == DIR_UP)
            t = (q >= lim);
        else
            t = (q == '0);
    end

endmodule

// File: rtl/contador_limite_m.sv
// N-bit counter with programmable terminal value, up/down and wrap/saturate.
module contador_limite_m
    import contador_limite_m_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         clr,
    input  logic         ld,
    input  logic         ent,
    input  logic         enp,
    input  logic         dir,
    input  logic         sat,
    input  logic [N-1:0] lim,
    input  logic [N-1:0] D,
    output logic [N-1:0] Q,
    output logic         rco,
    output logic         fim,
    output logic         ovf
);

    logic  t;
    acao_t acao;

    comparador_limite #(.N(N)) u_comp (
        .q   (Q),
        .lim (lim),
        .dir (dir),
        .t   (t)
    );

    assign acao = decide_acao(clr, ld, ent && enp);

    always_ff @(posedge clock) begin
        unique case (acao)
            ACAO_LIMPA: begin
                Q   <= '0;
                fim <= 1'b0;
                ovf <= 1'b0;
            end
            ACAO_CARGA: begin
                Q   <= (D > lim) ? lim : D;
                fim <= 1'b0;
                ovf <= 1'b0;
            end
            ACAO_CONTA: begin
                fim <= t;
                if (t && sat == MODO_SAT)
                    ovf <= 1'b1;
                // Below lim going up / above 0 going down, a plain step is safe.
                if (!t)
                    Q <= (dir == DIR_UP) ? Q + 1'b1 : Q - 1'b1;
                else if (dir == DIR_UP)
                    Q <= (sat == MODO_SAT) ? lim : '0;
                else
                    Q <= (sat == MODO_SAT) ? '0 : lim;
            end
            default: begin
                fim <= 1'b0;
            end
        endcase
    end

    always_comb begin
        rco = ent && t;
    end

endmodule

// File: tb/tb_contador_limite_m.sv
// Directed plan plus random traffic against a range-based reference model.
module tb_contador_limite_m;

    logic       clock;
    logic       clr, ld, ent, enp, dir, sat;
    logic [3:0] lim, D, Q;
    logic       rco, fim, ovf;

    int passed = 0;
    int total  = 0;
    int mq     = 0;
    bit mfim   = 0;
    bit movf   = 0;

    contador_limite_m #(.N(4)) dut (
        .clock (clock),
        .clr   (clr),
        .ld    (ld),
        .ent   (ent),
        .enp   (enp),
        .dir   (dir),
        .sat   (sat),
        .lim   (lim),
        .D     (D),
        .Q     (Q),
        .rco   (rco),
        .fim   (fim),
        .ovf   (ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Drive one cycle, check rco before the edge and the registers after it.
    task automatic step(input bit c, input bit l, input bit e,
                        input bit p, input bit dr, input bit s,
                        input int lm, input int dd);
        int  nat;
        bit  fora;
        bit  exp_rco;
        clr = c; ld = l; ent = e; enp = p;
        dir = dr; sat = s;
        lim = lm[3:0]; D = dd[3:0];
        #1;
        exp_rco = e && (dr ? (mq + 1 > lm) : (mq == 0));
        chk("rco", {15'd0, rco}, {15'd0, exp_rco});
        if (c) begin
            mq = 0; mfim = 0; movf = 0;
        end else if (l) begin
            mq = (dd < lm) ? dd : lm;
            mfim = 0; movf = 0;
        end else if (e && p) begin
            nat  = dr ? mq + 1 : mq - 1;
            fora = dr ? (nat > lm) : (nat < 0);
            mfim = fora;
            if (fora && s) movf = 1;
            if (!fora)
                mq = nat;
            else if (s)
                mq = dr ? lm : 0;
            else
                mq = dr ? 0 : lm;
        end else begin
            mfim = 0;
        end
        @(posedge clock);
        #1;
        chk("Q", {12'd0, Q}, mq[15:0]);
        chk("fim", {15'd0, fim}, {15'd0, mfim});
        chk("ovf", {15'd0, ovf}, {15'd0, movf});
    endtask

    initial begin
        clr = 1; ld = 0; ent = 0; enp = 0;
        dir = 1; sat = 0; lim = 4'd9; D = 0;

        step(1, 0, 0, 0, 1, 0, 9, 0);
        chk("reset_Q", {12'd0, Q}, 16'd0);

        // 1: up wrap lim=9
        for (int i = 0; i < 12; i++) step(0, 0, 1, 1, 1, 0, 9, 0);
        chk("wrap_Q2", {12'd0, Q}, 16'd2);

        // 2: up saturate lim=5, then load 2
        step(1, 0, 0, 0, 1, 1, 5, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 1, 1, 1, 5, 0);
        chk("sat_ovf", {15'd0, ovf}, 16'd1);
        step(0, 1, 1, 1, 1, 1, 5, 2);
        chk("ld_Q2", {12'd0, Q}, 16'd2);

        // 3: down wrap lim=3 from 1
        step(0, 1, 0, 0, 0, 0, 3, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 0, 0, 3, 0);
        chk("down_Q0", {12'd0, Q}, 16'd0);

        // 4: load clamp, clr priority, enp hold
        step(0, 1, 0, 0, 1, 0, 7, 12);
        chk("clamp_Q7", {12'd0, Q}, 16'd7);
        step(0, 0, 1, 1, 1, 1, 7, 0);
        step(1, 1, 1, 1, 1, 1, 7, 5);
        step(0, 1, 0, 0, 1, 0, 7, 7);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 1, 0, 7, 0);

        // 5: limit change mid-count, up then down
        step(0, 1, 0, 0, 1, 0, 15, 8);
        step(0, 0, 1, 1, 1, 0, 4, 0);
        chk("limchg_fim", {15'd0, fim}, 16'd1);
        step(0, 1, 0, 0, 0, 0, 15, 8);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 0, 0, 4, 0);
        chk("limchg_dn", {12'd0, Q}, 16'd4);

        // 6: lim=0, then clr while saturating
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 1, 1, 0, 0);
        step(0, 0, 0, 1, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0, 1, 0, 0);
        step(1, 0, 1, 1, 1, 1, 0, 0);
        chk("clr_ovf", {15'd0, ovf}, 16'd0);

        // random traffic
        begin
            int rl;
            rl = 9;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 15) == 0) rl = $urandom_range(0, 15);
                step($urandom_range(0, 40) == 0,
                     $urandom_range(0, 12) == 0,
                     $urandom_range(0, 5) != 0,
                     $urandom_range(0, 5) != 0,
                     $urandom_range(0, 9) < 7,
                     $urandom_range(0, 1) == 1,
                     rl, $urandom_range(0, 15));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
